// File: rtl/orb_stage_sequencer.sv
// Frame-level sequencer for the ORB front end: extend -> FAST -> descriptor, with shared-RAM ownership.
// Optional stage watchdog enabled by defining ORB_SEQ_WATCHDOG_EN.
module orb_stage_sequencer #(
    parameter int STAGE_GAP      = 2,
    parameter int TIMEOUT_CYCLES = 400000,
    parameter int FCNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_req,
    output logic              frame_ack,
    output logic              start_extend,
    input  logic              extend_done,
    output logic              start_fast,
    input  logic              fast_done,
    output logic              start_desc,
    input  logic              desc_done,
    output logic [1:0]        ram_owner,
    output logic              busy,
    output logic              frame_done,
    output logic              err_timeout,
    input  logic              err_clr,
    output logic [FCNT_W-1:0] frame_cnt
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_EXT_START,
        S_EXT_RUN,
        S_GAP1,
        S_FAST_START,
        S_FAST_RUN,
        S_GAP2,
        S_DESC_START,
        S_DESC_RUN,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_ext_q;
    logic              r_fast_q;
    logic              r_desc_q;
    logic              w_ext_edge;
    logic              w_fast_edge;
    logic              w_desc_edge;
    logic [3:0]        r_gap_cnt;
    logic              w_gap_last;
    logic              w_err;
    logic              w_timeout;
    logic [1:0]        w_owner_nxt;
    logic              r_frame_ack;
    logic              r_start_extend;
    logic              r_start_fast;
    logic              r_start_desc;
    logic [1:0]        r_ram_owner;
    logic              r_busy;
    logic              r_frame_done;
    logic [FCNT_W-1:0] r_frame_cnt;

    assign w_ext_edge  = extend_done & ~r_ext_q;
    assign w_fast_edge = fast_done & ~r_fast_q;
    assign w_desc_edge = desc_done & ~r_desc_q;
    assign w_gap_last  = (r_gap_cnt == 4'(STAGE_GAP - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ext_q  <= 1'b0;
            r_fast_q <= 1'b0;
            r_desc_q <= 1'b0;
        end else begin
            r_ext_q  <= extend_done;
            r_fast_q <= fast_done;
            r_desc_q <= desc_done;
        end
    end

`ifdef ORB_SEQ_WATCHDOG_EN
    logic [18:0] r_wd_cnt;
    logic        r_err;
    logic        w_in_stage;
    logic        w_stage_entry;
    logic        w_cur_edge;

    assign w_in_stage = (r_state == S_EXT_START)  || (r_state == S_EXT_RUN)  ||
                        (r_state == S_FAST_START) || (r_state == S_FAST_RUN) ||
                        (r_state == S_DESC_START) || (r_state == S_DESC_RUN);
    assign w_stage_entry = (w_state_nxt == S_EXT_START) || (w_state_nxt == S_FAST_START) ||
                           (w_state_nxt == S_DESC_START);
    assign w_cur_edge = ((r_state == S_EXT_START)  || (r_state == S_EXT_RUN))  ? w_ext_edge  :
                        ((r_state == S_FAST_START) || (r_state == S_FAST_RUN)) ? w_fast_edge :
                        ((r_state == S_DESC_START) || (r_state == S_DESC_RUN)) ? w_desc_edge :
                        1'b0;
    // A done edge arriving in the expiry cycle still counts as a normal completion.
    assign w_timeout = w_in_stage && (r_wd_cnt == 19'(TIMEOUT_CYCLES - 1)) && !w_cur_edge;
    assign w_err     = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt <= 19'd0;
        end else if (w_stage_entry) begin
            r_wd_cnt <= 19'd0;
        end else if (w_in_stage) begin
            r_wd_cnt <= r_wd_cnt + 19'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end
`else
    logic w_unused;

    assign w_timeout = 1'b0;
    assign w_err     = 1'b0;
    assign w_unused  = err_clr ^ (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap_cnt <= 4'd0;
        end else if ((r_state == S_GAP1) || (r_state == S_GAP2)) begin
            r_gap_cnt <= r_gap_cnt + 4'd1;
        end else begin
            r_gap_cnt <= 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:                    if (frame_req && !w_err) w_state_nxt = S_EXT_START;
            S_EXT_START,  S_EXT_RUN:   w_state_nxt = w_ext_edge  ? S_GAP1 : S_EXT_RUN;
            S_GAP1:                    if (w_gap_last) w_state_nxt = S_FAST_START;
            S_FAST_START, S_FAST_RUN:  w_state_nxt = w_fast_edge ? S_GAP2 : S_FAST_RUN;
            S_GAP2:                    if (w_gap_last) w_state_nxt = S_DESC_START;
            S_DESC_START, S_DESC_RUN:  w_state_nxt = w_desc_edge ? S_DONE : S_DESC_RUN;
            S_DONE:                    w_state_nxt = S_IDLE;
            default:                   w_state_nxt = S_IDLE;
        endcase
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_comb begin
        w_owner_nxt = 2'd0;
        case (w_state_nxt)
            S_EXT_START,  S_EXT_RUN:  w_owner_nxt = 2'd1;
            S_FAST_START, S_FAST_RUN: w_owner_nxt = 2'd2;
            S_DESC_START, S_DESC_RUN: w_owner_nxt = 2'd3;
            default:                  w_owner_nxt = 2'd0;
        endcase
    end

    // Outputs are decoded from the next state so each one lines up with the state it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_ack    <= 1'b0;
            r_start_extend <= 1'b0;
            r_start_fast   <= 1'b0;
            r_start_desc   <= 1'b0;
            r_ram_owner    <= 2'd0;
            r_busy         <= 1'b0;
            r_frame_done   <= 1'b0;
            r_frame_cnt    <= '0;
        end else begin
            r_frame_ack    <= (w_state_nxt == S_EXT_START);
            r_start_extend <= (w_state_nxt == S_EXT_START);
            r_start_fast   <= (w_state_nxt == S_FAST_START);
            r_start_desc   <= (w_state_nxt == S_DESC_START);
            r_ram_owner    <= w_owner_nxt;
            r_busy         <= (w_state_nxt != S_IDLE);
            r_frame_done   <= (w_state_nxt == S_DONE);
            if (w_state_nxt == S_DONE) begin
                r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
            end
        end
    end

    assign frame_ack    = r_frame_ack;
    assign start_extend = r_start_extend;
    assign start_fast   = r_start_fast;
    assign start_desc   = r_start_desc;
    assign ram_owner    = r_ram_owner;
    assign busy         = r_busy;
    assign frame_done   = r_frame_done;
    assign err_timeout  = w_err;
    assign frame_cnt    = r_frame_cnt;

endmodule

// File: doc/orb_stage_sequencer.md
Name: orb_stage_sequencer

Overview:
Frame-level controller for the ORB front end. Launches the border-extension stage, the FAST detector and the descriptor stage in order, one at a time. Grants ownership of the shared 678x518 extended-image RAM to exactly one stage at a time. Reports frame completion and stage timeouts.

Parameters:
STAGE_GAP, 2, idle cycles between a stage's done edge and the next stage's start (pipeline drain); legal range 1..15
TIMEOUT_CYCLES, 400000, maximum cycles a stage may spend in START+RUN before abort (>351204 extended words); legal range 2..2^19-1
FCNT_W, 16, width of the frame counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
frame_req  in  1  level request to process one frame
frame_ack  out  1  one-cycle pulse when the request is accepted
start_extend  out  1  one-cycle start pulse to the border-extension stage
extend_done  in  1  completion from border extension; may stay high up to 2 cycles; rising edge used
start_fast  out  1  one-cycle start pulse to the FAST detector
fast_done  in  1  FAST completion; rising edge used
start_desc  out  1  one-cycle start pulse to the descriptor stage
desc_done  in  1  descriptor completion; rising edge used
ram_owner  out  2  0 none, 1 extend writer, 2 FAST reader, 3 descriptor reader
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse on successful frame completion
err_timeout  out  1  sticky stage-timeout flag
err_clr  in  1  clears err_timeout
frame_cnt  out  FCNT_W  count of completed frames

Behaviour:
- Reset: clock and reset are one clock `clk` and asynchronous active-low `rst_n`. Reset forces state IDLE and all outputs to 0, including frame_cnt. Reset mid-frame abandons the frame silently.
- All outputs are registered. Pulses are asserted exactly in the cycle the FSM occupies the corresponding state.
- Edge detect: done_q registers of each done input; edge = done & ~done_q. done_q reset to 0.
- States: IDLE, EXT_START, EXT_RUN, GAP1, FAST_START, FAST_RUN, GAP2, DESC_START, DESC_RUN, DONE.
- IDLE: if frame_req=1 and err_timeout=0, go to EXT_START. Otherwise stay.
- EXT_START (1 cycle): frame_ack=1, start_extend=1, ram_owner=1. Then go to EXT_RUN.
- EXT_RUN: ram_owner=1. An extend_done edge in EXT_START or EXT_RUN goes to GAP1.
- GAP1/GAP2: ram_owner=0. Gap counter runs STAGE_GAP cycles, then goes to FAST_START or DESC_START respectively.
- FAST_START / FAST_RUN: start_fast=1 for one cycle, ram_owner=2. A fast_done edge goes to GAP2.
- DESC_START / DESC_RUN: start_desc=1 for one cycle, ram_owner=3. A desc_done edge goes to DONE.
- DONE (1 cycle): frame_done=1, frame_cnt increments (wraps from all-ones to 0), ram_owner=0. Then go to IDLE.
- Latency: frame_req high in IDLE at cycle N gives start_extend in N+1. A done edge at cycle T gives the next start at T+1+STAGE_GAP.
- Done edges are ignored unless they belong to the current stage. They are not remembered.
- frame_req while busy: ignored, no ack. A request held high through DONE is accepted from the following IDLE cycle.
- err_clr: clears err_timeout next cycle in any state. err_clr and frame_req together in IDLE with the error set: the clear wins, and the request is accepted one cycle later.
- ram_owner never changes directly between two nonzero values. It always passes through 0 for at least STAGE_GAP cycles.

Optional Feature:
ORB_SEQ_WATCHDOG_EN
- Defined: a 19-bit stage cycle counter is cleared on each *_START entry and counts in START+RUN.
- On reaching TIMEOUT_CYCLES-1 without the done edge:
  - err_timeout is set;
  - ram_owner goes to 0;
  - the FSM goes to IDLE;
  - there is no frame_done and no frame_cnt increment.
- A done edge in the same cycle as expiry wins: normal advance, no error.
- Undefined: no counter; err_timeout is tied 0; err_clr is unused; stages are waited on indefinitely.

Test Plan:
Nominal frame (STAGE_GAP=2): frame_req pulse at cycle 10 -> frame_ack and start_extend at cycle 11. extend_done at cycle 20 -> start_fast at 23. fast_done at 40 -> start_desc at 43. desc_done at 60 -> frame_done at 61, frame_cnt=1, busy=0 at 62.
Ownership: ram_owner sequence 1 (11-20), 0 (21-22), 2 (23-40), 0 (41-42), 3 (43-60), 0 after. Never 1->2 or 2->3 directly.
Spurious/long done: fast_done high during EXT_RUN -> ignored. extend_done held high 2 cycles -> a single advance. frame_req held high during a frame -> exactly one frame_ack per frame.
Watchdog (macro defined, TIMEOUT_CYCLES=1000): no fast_done after start_fast -> err_timeout=1 exactly 1000 cycles after start_fast, IDLE, ram_owner=0. frame_req then gets no ack until err_clr, then ack 2 cycles after err_clr.
Counter wrap (FCNT_W=4): 16 complete frames -> frame_cnt returns to 0.
Async reset asserted mid-FAST_RUN -> all outputs 0 immediately. After release, a new frame_req starts from EXT_START.
